// File: rtl/wf_7seg_pkg.sv
`default_nettype none
// ============================================================================
// wf_7seg_pkg : shared types and constants for the 7-segment display scheduler
// Rev 1.0
// ============================================================================
package wf_7seg_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_e;

   localparam logic [1:0] COLON_ON   = 2'b00;
   localparam logic [1:0] COLON_DP   = 2'b01;
   localparam logic [1:0] COLON_NONE = 2'b11;

   localparam int BCD_W = 4;

endpackage
`default_nettype wire

// File: rtl/wf_rr_pick.sv
`default_nettype none
// ============================================================================
// wf_rr_pick : combinational round-robin picker, search begins at start_idx
// Rev 1.0
// ============================================================================
module wf_rr_pick #(
   parameter int NREQ  = 3,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] start_idx,
   output logic [NREQ-1:0]  win_oh,
   output logic [IDX_W-1:0] win_idx,
   output logic             valid
);

   always_comb begin
      int idx;
      idx     = 0;
      win_oh  = '0;
      win_idx = '0;
      valid   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(start_idx) + k) % NREQ;
         if (!valid && req[idx]) begin
            win_oh[idx] = 1'b1;
            win_idx     = IDX_W'(idx);
            valid       = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wf_7seg_sched.sv
`default_nettype none
// ============================================================================
// wf_7seg_sched : round-robin display scheduler with dwell time and scan tick
// Rev 1.0
// ============================================================================
module wf_7seg_sched
   import wf_7seg_pkg::*;
#(
   parameter int NREQ         = 3,
   parameter int SCAN_DIV     = 16000,
   parameter int DWELL_FRAMES = 200
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [16*NREQ-1:0]    bcd_in,
   input  logic [2*NREQ-1:0]     colon_in,
   output logic [NREQ-1:0]       grant,
   output logic                  scan_enable,
   output logic [BCD_W-1:0]      digit0,
   output logic [BCD_W-1:0]      digit1,
   output logic [BCD_W-1:0]      digit2,
   output logic [BCD_W-1:0]      digit3,
   output logic [1:0]            colon
);

   localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TICK_W  = $clog2(SCAN_DIV);
   localparam int DWELL_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NREQ - 1);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SCAN_DIV - 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_FRAMES - 1);

   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [2:0]         phase_q, phase_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   state_e             state_q, state_d;
   logic [NREQ-1:0]    grant_q, grant_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [4*BCD_W-1:0] disp_q, disp_d;
   logic [1:0]         colon_q, colon_d;

   logic               fb;
   logic               dwell_sat;
   logic               load;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W-1:0]   start_idx;
   logic [NREQ-1:0]    pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   logic [4*BCD_W-1:0] bcd_arr [NREQ];
   logic [1:0]         col_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign bcd_arr[i] = bcd_in[16*i +: 16];
      assign col_arr[i] = colon_in[2*i +: 2];
   end

   assign scan_enable = (tick_q == TICK_LAST);
   assign fb          = scan_enable && (phase_q == 3'd4);
   assign dwell_sat   = (dwell_q == DWELL_MAX);
   // idx_q holds the current grant in SHOW and the last grant in IDLE
   assign start_idx   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

   wf_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req       (req),
      .start_idx (start_idx),
      .win_oh    (pick_oh),
      .win_idx   (pick_idx),
      .valid     (pick_valid)
   );

   always_comb begin
      tick_d  = scan_enable ? '0 : tick_q + 1'b1;
      phase_d = phase_q;
      if (scan_enable) begin
         phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      load    = 1'b0;
      sel_idx = idx_q;
      if (fb) begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_d = SHOW;
                  grant_d = pick_oh;
                  idx_d   = pick_idx;
                  dwell_d = '0;
                  load    = 1'b1;
                  sel_idx = pick_idx;
               end
            end
            SHOW: begin
               if (!req[idx_q]) begin
                  if (pick_valid) begin
                     grant_d = pick_oh;
                     idx_d   = pick_idx;
                     dwell_d = '0;
                     load    = 1'b1;
                     sel_idx = pick_idx;
                  end else begin
                     state_d = IDLE;
                     grant_d = '0;
                  end
               end else if (dwell_sat && pick_valid && (pick_idx != idx_q)) begin
                  grant_d = pick_oh;
                  idx_d   = pick_idx;
                  dwell_d = '0;
                  load    = 1'b1;
                  sel_idx = pick_idx;
               end else begin
                  load = 1'b1;
                  if (!dwell_sat) begin
                     dwell_d = dwell_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      disp_d  = load ? bcd_arr[sel_idx] : disp_q;
      colon_d = load ? col_arr[sel_idx] : colon_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q  <= '0;
         phase_q <= '0;
         dwell_q <= '0;
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         disp_q  <= '0;
         colon_q <= COLON_NONE;
      end else begin
         tick_q  <= tick_d;
         phase_q <= phase_d;
         dwell_q <= dwell_d;
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         disp_q  <= disp_d;
         colon_q <= colon_d;
      end
   end

   assign grant  = grant_q;
   assign digit0 = disp_q[0*BCD_W +: BCD_W];
   assign digit1 = disp_q[1*BCD_W +: BCD_W];
   assign digit2 = disp_q[2*BCD_W +: BCD_W];
   assign digit3 = disp_q[3*BCD_W +: BCD_W];
   assign colon  = colon_q;

endmodule
`default_nettype wire
